// File: rtl/mailbox_pkg.sv
// Shared constants for the path-planning mailbox: register offsets inside the
// 32-byte MMIO window and the PREV_NODE reset value.
package mailbox_pkg;

  localparam int WIN_BYTES = 32;
  localparam int WIN_BITS  = $clog2(WIN_BYTES);

  localparam logic [4:0] OFF_START = 5'h00;
  localparam logic [4:0] OFF_END   = 5'h04;
  localparam logic [4:0] OFF_NODE  = 5'h08;
  localparam logic [4:0] OFF_DONE  = 5'h0C;
  localparam logic [4:0] OFF_PREV  = 5'h10;

  localparam logic [31:0] PREV_RST = 32'd255;

endpackage

// File: rtl/node_fifo.sv
// Node FIFO: synchronous push/pop, registered head pointer, drops pushes that
// arrive while full unless a pop frees the slot in the same edge.
module node_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic                     valid,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_ok, push_ok;

  assign valid   = (count_q != '0);
  assign full    = (count_q == CNT_MAX);
  assign pop_ok  = pop & valid;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push_ok = push & (~full | pop_ok);
  assign drop    = push & ~push_ok;
  assign count   = count_q;
  assign rdata   = valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (push_ok && !pop_ok)      count_d = count_q + CNT_ONE;
    else if (pop_ok && !push_ok) count_d = count_q - CNT_ONE;
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; rdata is gated by valid so stale entries never show.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/path_mailbox.sv
// MMIO mailbox for path planning: control-word registers, readback mux and a
// node FIFO fed by NODE_POINT stores and drained by a valid/ready consumer.
module path_mailbox
  import mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int          DEPTH     = 16,
  parameter int          NODE_W    = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    MemWrite,
  input  logic [31:0]             DataAdr,
  input  logic [31:0]             WriteData,
  output logic                    mb_hit,
  output logic [31:0]             mb_rdata,
  output logic                    node_valid,
  output logic [NODE_W-1:0]       node_data,
  input  logic                    node_ready,
  output logic [$clog2(DEPTH):0]  node_count,
  output logic                    overflow,
  output logic                    cpu_done,
  output logic                    path_done
);

  logic [31:0] start_q, start_d;
  logic [31:0] end_q, end_d;
  logic [31:0] node_q, node_d;
  logic        done_q, done_d;
  logic [31:0] prev_q, prev_d;
  logic        overflow_q, overflow_d;

  logic [4:0]  off;
  logic        wr_en;
  logic        node_push;
  logic        node_drop;
  logic        unused_full;

  // Misaligned addresses are treated as outside the window entirely.
  assign off       = DataAdr[4:0];
  assign mb_hit    = (DataAdr[31:WIN_BITS] == BASE_ADDR[31:WIN_BITS]) &&
                     (DataAdr[1:0] == 2'b00);
  assign wr_en     = MemWrite & mb_hit;
  assign node_push = wr_en & (off == OFF_NODE);

  node_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (NODE_W)
  ) u_node_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (node_push),
    .pop   (node_ready),
    .wdata (WriteData[NODE_W-1:0]),
    .valid (node_valid),
    .rdata (node_data),
    .count (node_count),
    .full  (unused_full),
    .drop  (node_drop)
  );

  always_comb begin
    start_d    = start_q;
    end_d      = end_q;
    node_d     = node_q;
    done_d     = done_q;
    prev_d     = prev_q;
    overflow_d = overflow_q | node_drop;
    if (wr_en) begin
      case (off)
        OFF_START: start_d = WriteData;
        OFF_END:   end_d   = WriteData;
        OFF_NODE:  node_d  = WriteData;
        OFF_DONE:  done_d  = WriteData[0];
        OFF_PREV:  prev_d  = WriteData;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_q    <= '0;
      end_q      <= '0;
      node_q     <= '0;
      done_q     <= 1'b0;
      prev_q     <= PREV_RST;
      overflow_q <= 1'b0;
    end else begin
      start_q    <= start_d;
      end_q      <= end_d;
      node_q     <= node_d;
      done_q     <= done_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  // Reads see current state only, so a same-cycle write returns the old value.
  always_comb begin
    mb_rdata = '0;
    if (mb_hit) begin
      case (off)
        OFF_START: mb_rdata = start_q;
        OFF_END:   mb_rdata = end_q;
        OFF_NODE:  mb_rdata = node_q;
        OFF_DONE:  mb_rdata = {31'b0, done_q};
        OFF_PREV:  mb_rdata = prev_q;
        default:   mb_rdata = '0;
      endcase
    end
  end

  assign overflow  = overflow_q;
  assign cpu_done  = done_q;
  assign path_done = done_q & ~node_valid;

endmodule

// File: tb/tb_path_mailbox.sv
// Self-checking bench for path_mailbox: register vector table, directed FIFO
// corner sequences, then random traffic against a queue-based reference model.
module tb_path_mailbox;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] DataAdr;
  logic [31:0] WriteData;
  logic        mb_hit;
  logic [31:0] mb_rdata;
  logic        node_valid;
  logic [4:0]  node_data;
  logic        node_ready;
  logic [4:0]  node_count;
  logic        overflow;
  logic        cpu_done;
  logic        path_done;

  int checks = 0;
  int errors = 0;

  path_mailbox dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .DataAdr    (DataAdr),
    .WriteData  (WriteData),
    .mb_hit     (mb_hit),
    .mb_rdata   (mb_rdata),
    .node_valid (node_valid),
    .node_data  (node_data),
    .node_ready (node_ready),
    .node_count (node_count),
    .overflow   (overflow),
    .cpu_done   (cpu_done),
    .path_done  (path_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic mb_write(input logic [31:0] adr, input logic [31:0] data);
    DataAdr   = adr;
    WriteData = data;
    MemWrite  = 1'b1;
    step();
    MemWrite  = 1'b0;
  endtask

  task automatic mb_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
    DataAdr = adr;
    #1;
    check(name, mb_rdata, exp);
  endtask

  // Register access vectors: optional write, then a readback one cycle later.
  typedef struct {
    logic        we;
    logic [31:0] wadr;
    logic [31:0] wdata;
    logic [31:0] radr;
    logic [31:0] exp_rdata;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[13];

  // Reference model state
  logic [31:0] m_regs [5];
  logic [4:0]  m_q [$];
  bit          m_ovf;

  function automatic bit m_hit(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32) && (a % 4 == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_regs[i] = 32'd0;
    m_regs[4] = 32'd255;
    m_q.delete();
    m_ovf = 0;
  endtask

  initial begin
    logic [4:0] exp_seq [$];

    vecs[0]  = '{1'b1, BASE + 32'h00, 32'd4,         BASE + 32'h00, 32'd4,         1'b1};
    vecs[1]  = '{1'b1, BASE + 32'h04, 32'd11,        BASE + 32'h04, 32'd11,        1'b1};
    vecs[2]  = '{1'b1, BASE + 32'h02, 32'd99,        BASE + 32'h02, 32'd0,         1'b0};
    vecs[3]  = '{1'b0, BASE + 32'h00, 32'd0,         BASE + 32'h00, 32'd4,         1'b1};
    vecs[4]  = '{1'b1, BASE + 32'h10, 32'h1234_5678, BASE + 32'h10, 32'h1234_5678, 1'b1};
    vecs[5]  = '{1'b1, BASE + 32'h0C, 32'hFFFF_FFFE, BASE + 32'h0C, 32'd0,         1'b1};
    vecs[6]  = '{1'b1, BASE + 32'h0C, 32'd3,         BASE + 32'h0C, 32'd1,         1'b1};
    vecs[7]  = '{1'b1, BASE + 32'h14, 32'd5,         BASE + 32'h14, 32'd0,         1'b1};
    vecs[8]  = '{1'b1, BASE + 32'h1C, 32'd5,         BASE + 32'h1C, 32'd0,         1'b1};
    vecs[9]  = '{1'b0, BASE,          32'd0,         BASE + 32'h20, 32'd0,         1'b0};
    vecs[10] = '{1'b0, BASE,          32'd0,         BASE - 32'd4,  32'd0,         1'b0};
    vecs[11] = '{1'b1, BASE + 32'h08, 32'hABCD_0007, BASE + 32'h08, 32'hABCD_0007, 1'b1};
    vecs[12] = '{1'b1, BASE + 32'h0C, 32'd0,         BASE + 32'h0C, 32'd0,         1'b1};

    reset = 1'b0; MemWrite = 1'b0; DataAdr = BASE; WriteData = '0; node_ready = 1'b0;
    step(); step();
    check("rst_valid", node_valid, 0);
    check("rst_count", node_count, 0);
    check("rst_data", node_data, 0);
    check("rst_cpu_done", cpu_done, 0);
    check("rst_path_done", path_done, 0);
    check("rst_overflow", overflow, 0);
    reset = 1'b1;
    step();
    mb_read("rst_start", BASE + 32'h00, 32'd0);
    mb_read("rst_end",   BASE + 32'h04, 32'd0);
    mb_read("rst_node",  BASE + 32'h08, 32'd0);
    mb_read("rst_done",  BASE + 32'h0C, 32'd0);
    mb_read("rst_prev",  BASE + 32'h10, 32'd255);

    for (int i = 0; i < 13; i++) begin
      MemWrite = vecs[i].we; DataAdr = vecs[i].wadr; WriteData = vecs[i].wdata;
      step();
      MemWrite = 1'b0; DataAdr = vecs[i].radr;
      #1;
      check($sformatf("vec%0d_rdata", i), mb_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_hit", i), mb_hit, vecs[i].exp_hit);
    end

    // The NODE vector pushed 7; drain it.
    check("vec_node_valid", node_valid, 1);
    check("vec_node_data", node_data, 7);
    node_ready = 1'b1; step(); node_ready = 1'b0;
    check("vec_node_empty", node_valid, 0);

    // Same-cycle read of a register being written returns the old value.
    DataAdr = BASE + 32'h04; WriteData = 32'd77; MemWrite = 1'b1;
    #1;
    check("rw_same_cycle_old", mb_rdata, 32'd11);
    step(); MemWrite = 1'b0;
    #1;
    check("rw_next_cycle_new", mb_rdata, 32'd77);

    // Queue four nodes, then drain on consecutive cycles.
    mb_write(BASE + 32'h08, 32'd4);
    mb_write(BASE + 32'h08, 32'd3);
    mb_write(BASE + 32'h08, 32'd8);
    mb_write(BASE + 32'h08, 32'd11);
    check("q4_count", node_count, 4);
    check("q4_data", node_data, 4);
    node_ready = 1'b1;
    exp_seq = '{5'd4, 5'd3, 5'd8, 5'd11};
    foreach (exp_seq[i]) begin
      check($sformatf("drain4_%0d_valid", i), node_valid, 1);
      check($sformatf("drain4_%0d_data", i), node_data, exp_seq[i]);
      step();
    end
    node_ready = 1'b0;
    check("drain4_empty", node_valid, 0);
    check("drain4_count", node_count, 0);

    // Overflow: 17 pushes with no pop.
    for (int i = 1; i <= 17; i++) begin
      mb_write(BASE + 32'h08, i);
      if (i == 16) begin
        check("full16_count", node_count, 16);
        check("full16_ovf", overflow, 0);
      end
    end
    check("full17_count", node_count, 16);
    check("full17_ovf", overflow, 1);
    mb_read("full17_node_reg", BASE + 32'h08, 32'd17);
    // Push with simultaneous pop while full.
    node_ready = 1'b1;
    mb_write(BASE + 32'h08, 32'd20);
    node_ready = 1'b0;
    check("full_pushpop_count", node_count, 16);
    check("full_pushpop_ovf", overflow, 1);
    exp_seq.delete();
    for (int i = 2; i <= 16; i++) exp_seq.push_back(i[4:0]);
    exp_seq.push_back(5'd20);
    node_ready = 1'b1;
    foreach (exp_seq[i]) begin
      check($sformatf("drain16_%0d", i), node_data, exp_seq[i]);
      step();
    end
    node_ready = 1'b0;
    check("drain16_empty", node_valid, 0);

    // DONE with two queued nodes.
    mb_write(BASE + 32'h08, 32'd5);
    mb_write(BASE + 32'h08, 32'd6);
    mb_write(BASE + 32'h0C, 32'd1);
    check("done_cpu", cpu_done, 1);
    check("done_path_busy", path_done, 0);
    node_ready = 1'b1;
    step();
    check("done_path_after_pop1", path_done, 0);
    step();
    node_ready = 1'b0;
    check("done_path_after_pop2", path_done, 1);
    mb_write(BASE + 32'h0C, 32'd0);
    check("undone_cpu", cpu_done, 0);
    check("undone_path", path_done, 0);

    // Reset mid-drain with five queued.
    for (int i = 21; i <= 25; i++) mb_write(BASE + 32'h08, i);
    mb_write(BASE + 32'h0C, 32'd1);
    node_ready = 1'b1;
    step();
    check("middrain_data", node_data, 22);
    reset = 1'b0;
    #1;
    check("midrst_valid", node_valid, 0);
    check("midrst_count", node_count, 0);
    check("midrst_data", node_data, 0);
    check("midrst_cpu_done", cpu_done, 0);
    check("midrst_path_done", path_done, 0);
    check("midrst_ovf", overflow, 0);
    node_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    mb_read("midrst_prev", BASE + 32'h10, 32'd255);
    mb_read("midrst_start", BASE + 32'h00, 32'd0);
    mb_write(BASE + 32'h08, 32'd9);
    check("postrst_data", node_data, 9);
    check("postrst_count", node_count, 1);

    // Random traffic against the reference model.
    reset = 1'b0;
    step();
    reset = 1'b1;
    model_reset();
    for (int it = 0; it < 800; it++) begin
      logic        we, rdy, push, pop, hit;
      logic [31:0] adr, wd, exp_rd;
      int          sel, idx;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: adr = BASE + 32'h08;
        4:          adr = BASE + 4 * $urandom_range(0, 7);
        5:          adr = BASE + $urandom_range(0, 31);
        6:          adr = $urandom;
        default:    adr = BASE + 4 * $urandom_range(0, 4);
      endcase
      wd  = $urandom;
      we  = ($urandom_range(0, 1) == 1);
      rdy = (it < 400) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      MemWrite = we; DataAdr = adr; WriteData = wd; node_ready = rdy;
      #1;
      hit = m_hit(adr);
      idx = (adr - BASE) / 4;
      exp_rd = (hit && idx < 5) ? m_regs[idx] : 32'd0;
      check("rnd_hit", mb_hit, hit);
      check("rnd_rdata", mb_rdata, exp_rd);
      check("rnd_valid", node_valid, m_q.size() != 0);
      check("rnd_data", node_data, (m_q.size() != 0) ? m_q[0] : 5'd0);
      check("rnd_count", node_count, m_q.size());
      check("rnd_ovf", overflow, m_ovf);
      check("rnd_cpu_done", cpu_done, m_regs[3][0]);
      check("rnd_path_done", path_done, m_regs[3][0] && m_q.size() == 0);
      step();
      pop  = rdy && (m_q.size() != 0);
      push = we && hit && (idx == 2);
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() == 16) m_ovf = 1;
        else m_q.push_back(wd[4:0]);
      end
      if (we && hit && idx < 5) m_regs[idx] = (idx == 3) ? (wd & 32'd1) : wd;
    end
    MemWrite = 1'b0; node_ready = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/path_mailbox.md
# path_mailbox

Memory-mapped mailbox that sits directly downstream of the RISC-V core's data-memory bus in the `0x0200_0000` MMIO window. It holds the path-planning control words (START_POINT, END_POINT, NODE_POINT, CPU_DONE, PREV_NODE) and queues every NODE_POINT store into a FIFO. A downstream consumer (motion controller or bench) drains that FIFO with a valid/ready handshake. The block also supplies read data so the core can load back the control words.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0200_0000, base of the mailbox window (32 bytes).
- `DEPTH`, 16, node FIFO entries (power of two).
- `NODE_W`, 5, node index width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemWrite`  in  1  core store strobe, one cycle per store.
- `DataAdr`  in  32  core data address.
- `WriteData`  in  32  core store data.
- `mb_hit`  out  1  `DataAdr` is inside the window; comb.
- `mb_rdata`  out  32  read data for `DataAdr`; comb.
- `node_valid`  out  1  FIFO non-empty.
- `node_data`  out  NODE_W  FIFO head.
- `node_ready`  in  1  consumer accepts the head.
- `node_count`  out  $clog2(DEPTH)+1  FIFO occupancy.
- `overflow`  out  1  sticky; a push was dropped.
- `cpu_done`  out  1  CPU_DONE bit 0.
- `path_done`  out  1  `cpu_done` & FIFO empty.

## Operation
- Register map as offsets from `BASE_ADDR`, word-aligned:
  - 0x00 START: R/W, 32 b.
  - 0x04 END: R/W, 32 b.
  - 0x08 NODE: write pushes `WriteData[NODE_W-1:0]` and stores the full word; read returns the last written word.
  - 0x0C DONE: R/W, only bit 0 is kept.
  - 0x10 PREV: R/W, 32 b.
- Offsets 0x14–0x1C:
  - Writes ignored; reads return 0.
  - `mb_hit` = 1.
- `DataAdr[1:0]` ≠ 0:
  - `mb_hit` = 0; writes ignored; `mb_rdata` = 0.
- Reset values: START 0, END 0, NODE 0, DONE 0, PREV 32'd255, FIFO empty, `overflow` 0.
- Outputs during reset:
  - `node_valid` = 0.
  - `node_count` = 0.
  - `cpu_done` = 0.
  - `path_done` = 0.
  - `node_data` = 0.
- Pop: `node_valid & node_ready` at a clock edge.
- Push: `MemWrite` & NODE hit at a clock edge.
- Full FIFO:
  - Push without a simultaneous pop is dropped; `overflow` sets.
  - NODE register still updates.
  - Push with a simultaneous pop is accepted; count is unchanged.
- Empty FIFO: push is accepted; a pop is impossible because `node_valid` = 0.
- Simultaneous push and pop when not full or empty: both execute; count is unchanged.
- Pointers wrap modulo DEPTH; count saturates at DEPTH.
- `overflow` clears only on reset.
- Writing DONE with bit0 = 0 clears `cpu_done`; the FIFO is unaffected.
- Reset asserted mid-operation: all state returns to reset values immediately; queued nodes are lost.

## Timing
- Register writes and FIFO push take effect at the rising edge that samples `MemWrite`. New values are visible on `mb_rdata`, `node_valid`, `node_count` and `cpu_done` in the following cycle.
- `mb_rdata` and `mb_hit` are combinational from `DataAdr` and current state, with zero latency. A same-cycle read of a register being written returns the old value.
- Pop latency: after a pop edge, `node_data` presents the next entry in the same cycle `node_valid` updates.
- Push to empty: `node_valid` = 1 one cycle after the push edge.
- `node_data` comes from a registered head pointer; no combinational path from `node_ready` to `node_data`/`node_valid`.
- `path_done` is combinational from registered `cpu_done` and count.
- Deassertion of `reset` is synchronised externally; the block needs no extra cycles after reset release.

## Structure
- Package `mailbox_pkg`:
  - Offset constants `OFF_START`=5'h00, `OFF_END`=5'h04, `OFF_NODE`=5'h08, `OFF_DONE`=5'h0C, `OFF_PREV`=5'h10.
  - `PREV_RST`=32'd255.
  - Window size 32.
- Sub-module `node_fifo`:
  - Parameterised DEPTH/WIDTH, synchronous push/pop, async active-low reset.
  - Outputs `valid`, `count`, `full`, `drop`.
- Top level:
  - Address decode.
  - Five registers.
  - Read mux.
  - `overflow` sticky.
  - `path_done`.

## Test plan
- Reset, then read all five offsets -> 0, 0, 0, 0, 255; `node_valid`=0, `node_count`=0.
- Write 0x0200_0000=4, 0x0200_0004=11, then read both -> `mb_rdata` 4 and 11 one cycle after each write; `mb_hit`=1; write to 0x0200_0002 -> ignored, `mb_hit`=0.
- NODE writes 4, 3, 8, 11 with `node_ready`=0 -> `node_count`=4, `node_data`=4. Then `node_ready`=1 -> `node_data` sequence 4, 3, 8, 11 on consecutive cycles, then `node_valid`=0.
- 17 NODE writes with no pop -> `node_count`=16 and `overflow`=1 after the 17th; the 17th value is absent from the drain. A push with simultaneous pop when full keeps the count at 16 and `overflow` unchanged.
- Write DONE=1 with 2 queued nodes -> `cpu_done`=1, `path_done`=0. `path_done`=1 in the cycle after the second pop; write DONE=0 -> both 0.
- Assert `reset` mid-drain with 5 queued -> all outputs reach reset values immediately, PREV reads 255 after release, and the next push is read back correctly.
